// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

   localparam int MIN_DATA_BITS = 5;

   typedef enum logic [2:0] {
      PAR_NONE  = 3'b000,
      PAR_EVEN  = 3'b001,
      PAR_ODD   = 3'b010,
      PAR_MARK  = 3'b011,
      PAR_SPACE = 3'b100
   } parity_mode_t;

   typedef enum logic [1:0] {
      STOP_1   = 2'b00,
      STOP_1_5 = 2'b01,
      STOP_2   = 2'b10
   } stop_bits_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } tx_state_t;

   // Reserved parity codes fall back to no parity.
   function automatic parity_mode_t decode_parity(input logic [2:0] cfg);
      case (cfg)
         3'b001:  return PAR_EVEN;
         3'b010:  return PAR_ODD;
         3'b011:  return PAR_MARK;
         3'b100:  return PAR_SPACE;
         default: return PAR_NONE;
      endcase
   endfunction

   function automatic stop_bits_t decode_stop(input logic [1:0] cfg);
      case (cfg)
         2'b00:   return STOP_1;
         2'b01:   return STOP_1_5;
         default: return STOP_2;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_shift_reg.sv
// Data shift register for the UART transmitter with running parity over shifted-out bits.
module uart_tx_shift_reg
   import uart_pkg::*;
#(
   parameter int MAX_DATA_BITS = 9
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     load,
   input  logic [MAX_DATA_BITS-1:0] load_data,
   input  logic                     shift,
   output logic                     bit_nxt,
   output logic                     par_nxt
);

   logic [MAX_DATA_BITS-1:0] sr_q, sr_d;
   logic                     par_q, par_d;

   // Parity folds in each bit as it leaves, so after N shifts it covers exactly N bits.
   always_comb begin
      sr_d  = sr_q;
      par_d = par_q;
      if (load) begin
         sr_d  = load_data;
         par_d = 1'b0;
      end else if (shift) begin
         sr_d  = {1'b0, sr_q[MAX_DATA_BITS-1:1]};
         par_d = par_q ^ sr_q[0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr_q  <= '0;
         par_q <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         par_q <= par_d;
      end
   end

   assign bit_nxt = sr_d[0];
   assign par_nxt = par_d;

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: frame sequencing, tick/bit counters, handshake and registered tx line.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ST_IDLE   | line marking, waiting for a word or break
//   ST_START  | start bit (low) for one bit period
//   ST_DATA   | data bits, LSB first
//   ST_PARITY | parity bit
//   ST_STOP   | stop bits, or one-bit mark after a break
//   ST_BREAK  | line held low while cfg_break is set
module uart_tx_engine
   import uart_pkg::*;
#(
   parameter int MAX_DATA_BITS = 9,
   parameter int OVERSAMPLE    = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     tick_en,
   input  logic [3:0]               cfg_data_bits,
   input  logic [2:0]               cfg_parity,
   input  logic [1:0]               cfg_stop,
   input  logic                     cfg_break,
   input  logic [MAX_DATA_BITS-1:0] s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic                     tx,
   output logic                     busy,
   output logic                     done
);

   localparam int TW = $clog2(2 * OVERSAMPLE);
   localparam int BW = $clog2(MAX_DATA_BITS + 1);

   localparam logic [TW-1:0] TICK_BIT = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TICK_1_5 = TW'(3 * OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_2   = TW'(2 * OVERSAMPLE - 1);

   function automatic logic [BW-1:0] clamp_bits(input logic [3:0] cfg);
      if (int'(cfg) < MIN_DATA_BITS) return BW'(MIN_DATA_BITS);
      if (int'(cfg) > MAX_DATA_BITS) return BW'(MAX_DATA_BITS);
      return BW'(cfg);
   endfunction

   tx_state_t    state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [BW-1:0] nbits_q, nbits_d;
   parity_mode_t par_mode_q, par_mode_d;
   stop_bits_t   stop_q, stop_d;
   logic         mab_q, mab_d;
   logic         tx_q, tx_d;
   logic         done_q, done_d;

   logic          bit_end, stop_end, accept, shift;
   logic          bit_nxt, par_nxt, par_bit;
   logic [TW-1:0] stop_tc;

   always_comb begin
      case (stop_q)
         STOP_1:   stop_tc = TICK_BIT;
         STOP_1_5: stop_tc = TICK_1_5;
         default:  stop_tc = TICK_2;
      endcase
   end

   assign bit_end  = tick_en && (tick_q == TICK_BIT);
   assign stop_end = tick_en && (state_q == ST_STOP) && (tick_q == stop_tc);
   assign s_ready  = !cfg_break && ((state_q == ST_IDLE) || stop_end);
   assign accept   = s_valid && s_ready;

   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      bit_d      = bit_q;
      nbits_d    = nbits_q;
      par_mode_d = par_mode_q;
      stop_d     = stop_q;
      mab_d      = mab_q;
      done_d     = 1'b0;
      shift      = 1'b0;

      if (tick_en) tick_d = tick_q + TW'(1);

      case (state_q)
         ST_IDLE: begin
            tick_d = '0;
            if (cfg_break) state_d = ST_BREAK;
         end
         ST_START: begin
            if (bit_end) begin
               tick_d  = '0;
               bit_d   = nbits_q;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               tick_d = '0;
               shift  = 1'b1;
               if (bit_q == BW'(1)) begin
                  state_d = (par_mode_q != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q - BW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               tick_d  = '0;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (stop_end) begin
               tick_d  = '0;
               done_d  = !mab_q;
               mab_d   = 1'b0;
               state_d = cfg_break ? ST_BREAK : ST_IDLE;
            end
         end
         ST_BREAK: begin
            tick_d = '0;
            if (!cfg_break) begin
               state_d = ST_STOP;
               stop_d  = STOP_1;
               mab_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Acceptance can only happen in IDLE or on the final stop tick, so it overrides both.
      if (accept) begin
         state_d    = ST_START;
         nbits_d    = clamp_bits(cfg_data_bits);
         par_mode_d = decode_parity(cfg_parity);
         stop_d     = decode_stop(cfg_stop);
      end
   end

   always_comb begin
      case (par_mode_q)
         PAR_EVEN:  par_bit = par_nxt;
         PAR_ODD:   par_bit = ~par_nxt;
         PAR_MARK:  par_bit = 1'b1;
         PAR_SPACE: par_bit = 1'b0;
         default:   par_bit = 1'b1;
      endcase
   end

   // tx is registered, so it is derived from the next state and next shift-register LSB.
   always_comb begin
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = bit_nxt;
         ST_PARITY: tx_d = par_bit;
         ST_BREAK:  tx_d = 1'b0;
         default:   tx_d = 1'b1;
      endcase
   end

   uart_tx_shift_reg #(
      .MAX_DATA_BITS(MAX_DATA_BITS)
   ) u_shift_reg (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (accept),
      .load_data(s_data),
      .shift    (shift),
      .bit_nxt  (bit_nxt),
      .par_nxt  (par_nxt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         nbits_q    <= BW'(MIN_DATA_BITS);
         par_mode_q <= PAR_NONE;
         stop_q     <= STOP_1;
         mab_q      <= 1'b0;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         nbits_q    <= nbits_d;
         par_mode_q <= par_mode_d;
         stop_q     <= stop_d;
         mab_q      <= mab_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != ST_IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frame shapes, back-to-back, break, clamp and reset.
module tb_uart_tx_engine;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tick_en;
   logic [3:0] cfg_data_bits;
   logic [2:0] cfg_parity;
   logic [1:0] cfg_stop;
   logic       cfg_break;
   logic [8:0] s_data;
   logic       s_valid;
   logic       s_ready, tx, busy, done;

   int vecs = 0;
   int errs = 0;
   int tick_div = 0;

   logic seg_lvl [16];
   int   seg_len [16];
   int   nseg;
   int   dn_cnt, rdy_cnt;

   uart_tx_engine #(
      .MAX_DATA_BITS(9),
      .OVERSAMPLE   (16)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .tick_en      (tick_en),
      .cfg_data_bits(cfg_data_bits),
      .cfg_parity   (cfg_parity),
      .cfg_stop     (cfg_stop),
      .cfg_break    (cfg_break),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .tx           (tx),
      .busy         (busy),
      .done         (done)
   );

   initial forever #5 clk = ~clk;

   // One tick every fourth clock, changed just after the rising edge.
   initial begin
      tick_en = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tick_en  = (tick_div == 3);
         tick_div = (tick_div + 1) % 4;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input logic [3:0] n, input logic [2:0] par, input logic [1:0] stp);
      cfg_data_bits = n;
      cfg_parity    = par;
      cfg_stop      = stp;
   endtask

   task automatic build(input logic [8:0] bits, input int n, input bit has_par,
                        input logic pbit, input int stop_ticks);
      seg_lvl[0] = 1'b0;
      seg_len[0] = 16;
      nseg = 1;
      for (int i = 0; i < n; i++) begin
         seg_lvl[nseg] = bits[i];
         seg_len[nseg] = 16;
         nseg++;
      end
      if (has_par) begin
         seg_lvl[nseg] = pbit;
         seg_len[nseg] = 16;
         nseg++;
      end
      seg_lvl[nseg] = 1'b1;
      seg_len[nseg] = stop_ticks;
      nseg++;
   endtask

   task automatic wait_tick();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         if (done)    dn_cnt++;
         if (s_ready) rdy_cnt++;
         k++;
      end while (!tick_en && k < 16);
      if (!tick_en) chk("tick_timeout", {31'd0, tick_en}, 32'd1);
   endtask

   // Counts, per expected segment, how many ticks carried the expected line level.
   task automatic walk(input string tag, input int first, input int last);
      int cnt;
      for (int s = first; s < last; s++) begin
         cnt = 0;
         for (int t = 0; t < seg_len[s]; t++) begin
            wait_tick();
            if (tx === seg_lvl[s]) cnt++;
         end
         chk($sformatf("%s_seg%0d", tag, s), cnt, seg_len[s]);
      end
   endtask

   task automatic end_frame(input string tag, input logic e_done, input logic e_tx, input logic e_busy);
      @(negedge clk);
      chk({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
      chk({tag, "_tx"},   {31'd0, tx},   {31'd0, e_tx});
      chk({tag, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
   endtask

   task automatic send(input string tag, input logic [8:0] d);
      @(negedge clk);
      s_data  = d;
      s_valid = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      chk({tag, "_start"}, {31'd0, tx}, 32'd0);
      dn_cnt  = 0;
      rdy_cnt = 0;
   endtask

   initial begin
      int bad, ticks;
      reset_n   = 1'b0;
      cfg_break = 1'b0;
      s_valid   = 1'b0;
      s_data    = '0;
      set_cfg(4'd8, 3'b000, 2'b00);
      dn_cnt  = 0;
      rdy_cnt = 0;

      repeat (3) @(negedge clk);
      chk("rst_tx",   {31'd0, tx},   32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("idle_tx",    {31'd0, tx},      32'd1);
      chk("idle_busy",  {31'd0, busy},    32'd0);
      chk("idle_ready", {31'd0, s_ready}, 32'd1);
      cfg_break = 1'b1;
      #1;
      chk("idle_ready_brk", {31'd0, s_ready}, 32'd0);
      cfg_break = 1'b0;

      // 8N1 0x55
      send("t1", 9'h055);
      build(9'h055, 8, 1'b0, 1'b0, 16);
      walk("t1", 0, nseg);
      chk("t1_early_done", dn_cnt, 0);
      end_frame("t1", 1'b1, 1'b1, 1'b0);

      // 7 bits, odd parity, two stop bits, 0x41: parity 1
      set_cfg(4'd7, 3'b010, 2'b10);
      send("t2", 9'h041);
      build(9'h041, 7, 1'b1, 1'b1, 32);
      walk("t2", 0, nseg);
      chk("t2_early_done", dn_cnt, 0);
      end_frame("t2", 1'b1, 1'b1, 1'b0);

      // 9 bits, even parity, 1.5 stop, 0x1A5: five ones, parity 1
      set_cfg(4'd9, 3'b001, 2'b01);
      send("t3", 9'h1A5);
      build(9'h1A5, 9, 1'b1, 1'b1, 24);
      walk("t3", 0, nseg);
      chk("t3_early_done", dn_cnt, 0);
      end_frame("t3", 1'b1, 1'b1, 1'b0);

      // Back-to-back with config change during the first frame
      set_cfg(4'd8, 3'b000, 2'b00);
      @(negedge clk);
      s_data  = 9'h0A3;
      s_valid = 1'b1;
      @(negedge clk);
      chk("b2b_start", {31'd0, tx}, 32'd0);
      s_data = 9'h03C;
      set_cfg(4'd7, 3'b010, 2'b11);
      dn_cnt  = 0;
      rdy_cnt = 0;
      build(9'h0A3, 8, 1'b0, 1'b0, 16);
      walk("b2b_a", 0, nseg);
      chk("b2b_a_early_done", dn_cnt, 0);
      chk("b2b_a_ready_cnt", rdy_cnt, 1);
      end_frame("b2b_a", 1'b1, 1'b0, 1'b1);
      s_valid = 1'b0;
      dn_cnt  = 0;
      // 0x3C in 7 bits has four ones: odd parity 1
      build(9'h03C, 7, 1'b1, 1'b1, 32);
      walk("b2b_b", 0, nseg);
      chk("b2b_b_early_done", dn_cnt, 0);
      end_frame("b2b_b", 1'b1, 1'b1, 1'b0);

      // Break while a word is offered
      set_cfg(4'd8, 3'b000, 2'b00);
      @(negedge clk);
      s_data    = 9'h05A;
      s_valid   = 1'b1;
      cfg_break = 1'b1;
      bad   = 0;
      ticks = 0;
      for (int k = 0; k < 400 && ticks < 50; k++) begin
         @(negedge clk);
         if (tx !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) bad++;
         if (tick_en) ticks++;
      end
      chk("brk_ticks", ticks, 50);
      chk("brk_hold", bad, 0);
      cfg_break = 1'b0;
      seg_lvl[0] = 1'b1;
      seg_len[0] = 16;
      dn_cnt = 0;
      walk("mab", 0, 1);
      chk("mab_done_seen", dn_cnt, 0);
      end_frame("mab", 1'b0, 1'b0, 1'b1);
      s_valid = 1'b0;
      dn_cnt  = 0;
      build(9'h05A, 8, 1'b0, 1'b0, 16);
      walk("postbrk", 0, nseg);
      end_frame("postbrk", 1'b1, 1'b1, 1'b0);

      // Lower clamp: 3 requested, 5 sent (sixth bit would be low)
      set_cfg(4'd3, 3'b000, 2'b00);
      send("clamp5", 9'h005);
      build(9'h005, 5, 1'b0, 1'b0, 16);
      walk("clamp5", 0, nseg);
      end_frame("clamp5", 1'b1, 1'b1, 1'b0);

      // Reset during the fourth data bit (a low bit)
      send("rst_mid", 9'h005);
      walk("rst_mid", 0, 4);
      for (int i = 0; i < 8; i++) wait_tick();
      chk("rst_mid_pre_tx", {31'd0, tx}, 32'd0);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_tx",   {31'd0, tx},   32'd1);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Upper clamp after reset: 12 requested, 9 sent, space parity 0
      set_cfg(4'd12, 3'b100, 2'b00);
      send("clamp9", 9'h0C3);
      build(9'h0C3, 9, 1'b1, 1'b0, 16);
      walk("clamp9", 0, nseg);
      end_frame("clamp9", 1'b1, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
